// File: rtl/an_product_pkg.sv
// Shared constants, FSM state type and AN-code correction helper for an_product_decoder.
package an_product_pkg;

  localparam int unsigned A_DEF     = 29;
  localparam int unsigned CW_W_DEF  = 14;
  localparam int unsigned MSG_W_DEF = 10;
  localparam int unsigned ROWS_DEF  = 6;
  localparam int unsigned COLS_DEF  = 6;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_DECIDE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // One DELTA table entry: quotient fix-up (r - e)/A for residue r, where e is the
  // unique +/-2^k (k < cw_w) congruent to r mod a. Residue 0 (or no match) gives 0.
  function automatic int delta_entry(input int unsigned a, input int unsigned cw_w,
                                     input int unsigned r);
    int p;
    int d;
    d = 0;
    if (r != 0 && r < a) begin
      for (int k = 0; k < int'(cw_w); k++) begin
        p = (1 << k) % int'(a);
        if (p == int'(r)) begin
          d = (int'(r) - (1 << k)) / int'(a);
        end else if (int'(a) - p == int'(r)) begin
          d = (int'(r) + (1 << k)) / int'(a);
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/an_barrett_lane.sv
// Combinational AN-code lane: Barrett quotient/residue of one codeword plus error flag.
// Residue port only exists when AN_PRODUCT_CORRECT_EN is defined.
module an_barrett_lane #(
  parameter int unsigned A     = 29,
  parameter int unsigned CW_W  = 14,
  parameter int unsigned MSG_W = 10,
  parameter int unsigned RW    = 5
) (
  input  logic [CW_W-1:0]  cw,
  output logic [MSG_W-1:0] q_c,
`ifdef AN_PRODUCT_CORRECT_EN
  output logic [RW-1:0]    r_c,
`endif
  output logic             err_c
);

  localparam int unsigned MU   = (1 << CW_W) / A;
  localparam int unsigned MU_W = $clog2(MU + 1);
  localparam int unsigned PW   = CW_W + MU_W;

  logic [PW-1:0]   prod;
  logic [CW_W-1:0] q_est;
  logic [CW_W:0]   rem;
  logic            over;
  logic [RW-1:0]   res;

  // Barrett estimate is at most one below the true quotient; one conditional subtract fixes it
  always_comb begin
    prod  = PW'(cw) * PW'(MU);
    q_est = CW_W'(prod >> CW_W);
    rem   = (CW_W+1)'(cw) - (CW_W+1)'(q_est) * (CW_W+1)'(A);
    over  = (rem >= (CW_W+1)'(A));
    q_c   = MSG_W'(q_est + CW_W'(over));
    res   = over ? RW'(rem - (CW_W+1)'(A)) : RW'(rem);
    err_c = (res != '0);
  end

`ifdef AN_PRODUCT_CORRECT_EN
  assign r_c = res;
`endif

endmodule

// File: rtl/an_product_decoder.sv
// Streaming AN-code product decoder: buffers a ROWS x COLS frame, flags rows/columns
// with nonzero residues and drains decoded messages with frame status.
// AN_PRODUCT_CORRECT_EN enables single-error correction; otherwise detection only.
module an_product_decoder
  import an_product_pkg::*;
#(
  parameter int unsigned A     = A_DEF,
  parameter int unsigned CW_W  = CW_W_DEF,
  parameter int unsigned MSG_W = MSG_W_DEF,
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned COLS  = COLS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COLS*CW_W-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COLS*MSG_W-1:0] out_data,
  output logic                  out_last,
  output logic                  out_corrected,
  output logic                  out_uncorr
);

  localparam int unsigned RW  = $clog2(A);
  localparam int unsigned RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned QRW = COLS * MSG_W;

  state_e             state_q, state_d;
  logic [RIW-1:0]     row_cnt_q, row_cnt_d;
  logic [RIW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [ROWS-1:0]    er_q, er_d;
  logic [COLS-1:0]    ec_q, ec_d;
  logic               corr_q, corr_d;
  logic               uncorr_q, uncorr_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [QRW-1:0]     out_data_q, out_data_d;
  logic [QRW-1:0]     qbuf_q [ROWS];
  logic [QRW-1:0]     qbuf_d [ROWS];

  logic [QRW-1:0]     row_q_c;
  logic [COLS-1:0]    row_err_c;
  logic               fire_in, fire_out;
  logic               clean_c, fix_en_c, uncorr_set_c;

  assign fire_in  = in_valid && in_ready_q;
  assign fire_out = out_valid_q && out_ready;

`ifdef AN_PRODUCT_CORRECT_EN
  localparam int unsigned DW  = MSG_W + 2;
  localparam int unsigned CIW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [COLS*RW-1:0]   row_r_c;
  logic [COLS*RW-1:0]   rbuf_q [ROWS];
  logic [COLS*RW-1:0]   rbuf_d [ROWS];
  logic signed [DW-1:0] delta_tbl [2**RW];
  logic [RIW-1:0]       hit_row_c;
  logic [CIW-1:0]       hit_col_c;
  logic [MSG_W-1:0]     q_sel_c;
  logic [RW-1:0]        r_sel_c;
  logic signed [DW-1:0] m_c;
  logic [QRW-1:0]       fixed_row_c;

  for (genvar g = 0; g < 2**RW; g++) begin : g_delta
    assign delta_tbl[g] = DW'(delta_entry(A, CW_W, g));
  end
`endif

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    an_barrett_lane #(
      .A     (A),
      .CW_W  (CW_W),
      .MSG_W (MSG_W),
      .RW    (RW)
    ) u_lane (
      .cw    (in_data[c*CW_W +: CW_W]),
      .q_c   (row_q_c[c*MSG_W +: MSG_W]),
`ifdef AN_PRODUCT_CORRECT_EN
      .r_c   (row_r_c[c*RW +: RW]),
`endif
      .err_c (row_err_c[c])
    );
  end

`ifdef AN_PRODUCT_CORRECT_EN
  // Locate the flagged cell and compute its corrected message and row
  always_comb begin
    hit_row_c = '0;
    hit_col_c = '0;
    q_sel_c   = '0;
    r_sel_c   = '0;
    for (int i = 0; i < ROWS; i++) if (er_q[i]) hit_row_c = RIW'(i);
    for (int j = 0; j < COLS; j++) if (ec_q[j]) hit_col_c = CIW'(j);
    fixed_row_c = qbuf_q[hit_row_c];
    for (int j = 0; j < COLS; j++) begin
      if (CIW'(j) == hit_col_c) begin
        q_sel_c = qbuf_q[hit_row_c][j*MSG_W +: MSG_W];
        r_sel_c = rbuf_q[hit_row_c][j*RW +: RW];
      end
    end
    m_c = $signed(DW'(q_sel_c)) + delta_tbl[r_sel_c];
    for (int j = 0; j < COLS; j++) begin
      if (CIW'(j) == hit_col_c) fixed_row_c[j*MSG_W +: MSG_W] = m_c[MSG_W-1:0];
    end
    clean_c      = (er_q == '0) && (ec_q == '0);
    fix_en_c     = ($countones(er_q) == 1) && ($countones(ec_q) == 1) &&
                   (m_c[DW-1:MSG_W] == '0);
    uncorr_set_c = !clean_c && !fix_en_c;
  end
`else
  // Detection only: any flagged cell makes the frame uncorrectable
  always_comb begin
    clean_c      = (er_q == '0) && (ec_q == '0);
    fix_en_c     = 1'b0;
    uncorr_set_c = !clean_c;
  end
`endif

  // Next-state, buffer and output computation
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    er_d        = er_q;
    ec_d        = ec_q;
    corr_d      = corr_q;
    uncorr_d    = uncorr_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    qbuf_d      = qbuf_q;
`ifdef AN_PRODUCT_CORRECT_EN
    rbuf_d      = rbuf_q;
`endif
    unique case (state_q)
      ST_LOAD: begin
        in_ready_d = 1'b1;
        if (fire_in) begin
          qbuf_d[row_cnt_q] = row_q_c;
`ifdef AN_PRODUCT_CORRECT_EN
          rbuf_d[row_cnt_q] = row_r_c;
`endif
          er_d[row_cnt_q] = |row_err_c;
          ec_d            = ec_q | row_err_c;
          if (row_cnt_q == RIW'(ROWS - 1)) begin
            row_cnt_d  = '0;
            in_ready_d = 1'b0;
            state_d    = ST_DECIDE;
          end else begin
            row_cnt_d = row_cnt_q + RIW'(1);
          end
        end
      end
      ST_DECIDE: begin
        state_d     = ST_DRAIN;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        out_last_d  = (ROWS == 1);
        drain_cnt_d = '0;
        corr_d      = fix_en_c;
        uncorr_d    = uncorr_set_c;
        out_data_d  = qbuf_q[0];
`ifdef AN_PRODUCT_CORRECT_EN
        if (fix_en_c) begin
          qbuf_d[hit_row_c] = fixed_row_c;
          if (hit_row_c == '0) out_data_d = fixed_row_c;
        end
`endif
      end
      ST_DRAIN: begin
        in_ready_d = 1'b0;
        if (fire_out) begin
          if (drain_cnt_q == RIW'(ROWS - 1)) begin
            state_d     = ST_LOAD;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            drain_cnt_d = '0;
            corr_d      = 1'b0;
            uncorr_d    = 1'b0;
            er_d        = '0;
            ec_d        = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + RIW'(1);
            out_data_d  = qbuf_q[drain_cnt_d];
            out_last_d  = (drain_cnt_d == RIW'(ROWS - 1));
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State, frame buffer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
      er_q        <= '0;
      ec_q        <= '0;
      corr_q      <= 1'b0;
      uncorr_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      qbuf_q      <= '{default: '0};
`ifdef AN_PRODUCT_CORRECT_EN
      rbuf_q      <= '{default: '0};
`endif
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      er_q        <= er_d;
      ec_q        <= ec_d;
      corr_q      <= corr_d;
      uncorr_q    <= uncorr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      qbuf_q      <= qbuf_d;
`ifdef AN_PRODUCT_CORRECT_EN
      rbuf_q      <= rbuf_d;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign out_data      = out_data_q;
  assign out_corrected = corr_q;
  assign out_uncorr    = uncorr_q;

endmodule

// File: tb/tb_an_product_decoder.sv
// Self-checking bench for an_product_decoder; reference model follows AN_PRODUCT_CORRECT_EN.
module tb_an_product_decoder;

  localparam int A     = 29;
  localparam int CW_W  = 14;
  localparam int MSG_W = 10;
  localparam int ROWS  = 6;
  localparam int COLS  = 6;
  localparam int CW_MAX = (1 << CW_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [COLS*CW_W-1:0]  in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [COLS*MSG_W-1:0] out_data;
  logic                  out_last;
  logic                  out_corrected;
  logic                  out_uncorr;

  int cw_frame [ROWS][COLS];
  int exp_msg  [ROWS][COLS];
  bit exp_corr;
  bit exp_uncorr;
  int n_cmp;
  int n_err;

  an_product_decoder #(
    .A(A), .CW_W(CW_W), .MSG_W(MSG_W), .ROWS(ROWS), .COLS(COLS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_corrected (out_corrected),
    .out_uncorr    (out_uncorr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COLS*CW_W-1:0] pack_row(input int rw);
    logic [COLS*CW_W-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) v[c*CW_W +: CW_W] = CW_W'(cw_frame[rw][c]);
    return v;
  endfunction

  function automatic logic [COLS*MSG_W-1:0] exp_row(input int rw);
    logic [COLS*MSG_W-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) v[c*MSG_W +: MSG_W] = MSG_W'(exp_msg[rw][c]);
    return v;
  endfunction

  // Reference: plain division/modulo, then search the +/-2^k error that explains the residue
  task automatic build_expected();
    bit er [ROWS];
    bit ec [COLS];
    int nr, nc, fr, fc, rr, e, m;
    nr = 0; nc = 0; fr = 0; fc = 0;
    for (int c = 0; c < COLS; c++) ec[c] = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      er[r] = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        exp_msg[r][c] = cw_frame[r][c] / A;
        if (cw_frame[r][c] % A != 0) begin
          er[r] = 1'b1; ec[c] = 1'b1; fr = r; fc = c;
        end
      end
    end
    for (int r = 0; r < ROWS; r++) nr += int'(er[r]);
    for (int c = 0; c < COLS; c++) nc += int'(ec[c]);
    exp_corr   = 1'b0;
    exp_uncorr = (nr != 0) || (nc != 0);
`ifdef AN_PRODUCT_CORRECT_EN
    if (nr == 1 && nc == 1) begin
      rr = cw_frame[fr][fc] % A;
      e  = 0;
      for (int k = 0; k < CW_W; k++) begin
        if ((1 << k) % A == rr) e = (1 << k);
        else if (A - (1 << k) % A == rr) e = -(1 << k);
      end
      m = (cw_frame[fr][fc] - e) / A;
      if (m >= 0 && m < (1 << MSG_W)) begin
        exp_msg[fr][fc] = m;
        exp_corr   = 1'b1;
        exp_uncorr = 1'b0;
      end
    end
`else
    e = 0; m = 0; rr = 0;
`endif
  endtask

  task automatic clean_frame(input bit rand_msg);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        cw_frame[r][c] = rand_msg ? A * int'($urandom_range(0, 560)) : A * (r * COLS + c);
  endtask

  task automatic inject(input int r, input int c, input int k, input bit neg);
    int p;
    p = 1 << k;
    if (neg && cw_frame[r][c] >= p) cw_frame[r][c] -= p;
    else if (cw_frame[r][c] + p <= CW_MAX) cw_frame[r][c] += p;
    else cw_frame[r][c] -= p;
  endtask

  task automatic send_frame(input bit gaps, input int nrows);
    bit accepted;
    for (int rw = 0; rw < nrows; rw++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          for (int c = 0; c < COLS; c++) in_data[c*CW_W +: CW_W] = CW_W'($urandom_range(0, CW_MAX));
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = pack_row(rw);
      accepted = 1'b0;
      for (int b = 0; b < 40 && !accepted; b++) begin
        accepted = (in_ready === 1'b1);
        @(posedge clk); #1;
      end
      check("in_accept", 64'(accepted), 64'(1));
      in_valid = 1'b0;
    end
  endtask

  // Called #1 after the edge that accepted the last row
  task automatic drain_frame(input int stall_row, input int stall_len, input bit rand_stall);
    int sl;
    check("decide_out_valid", 64'(out_valid), 64'(0));
    check("decide_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("latency_out_valid", 64'(out_valid), 64'(1));
    for (int k = 0; k < ROWS; k++) begin
      sl = (k == stall_row) ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
      out_ready = 1'b0;
      for (int s = 0; s < sl; s++) begin
        @(posedge clk); #1;
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_data", 64'(out_data), 64'(exp_row(k)));
        check("stall_flags", 64'({out_corrected, out_uncorr, out_last}),
              64'({exp_corr, exp_uncorr, 1'(k == ROWS - 1)}));
      end
      out_ready = 1'b1;
      check("row_valid", 64'(out_valid), 64'(1));
      check("row_data", 64'(out_data), 64'(exp_row(k)));
      check("row_flags", 64'({out_corrected, out_uncorr, out_last}),
            64'({exp_corr, exp_uncorr, 1'(k == ROWS - 1)}));
      check("row_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("post_out_valid", 64'(out_valid), 64'(0));
    check("post_in_ready", 64'(in_ready), 64'(1));
    check("post_status", 64'({out_corrected, out_uncorr}), 64'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_data"}, 64'(out_data), 64'(0));
    check({tag, "_flags"}, 64'({out_last, out_corrected, out_uncorr}), 64'(0));
  endtask

  initial begin
    int r1, c1, r2, c2;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    #1;
    check("release_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    check("in_ready_rise", 64'(in_ready), 64'(1));

    // Clean frame, messages 0..35
    clean_frame(1'b0);
    build_expected();
    send_frame(1'b0, ROWS);
    drain_frame(-1, 0, 1'b0);

    // Cell (2,3) = 100 with +2^5 error
    clean_frame(1'b0);
    cw_frame[2][3] = 2932;
    build_expected();
    send_frame(1'b1, ROWS);
    drain_frame(-1, 0, 1'b0);

    // Cell (0,0) = 5 with -2^0 error
    clean_frame(1'b0);
    cw_frame[0][0] = 144;
    build_expected();
    send_frame(1'b1, ROWS);
    drain_frame(-1, 0, 1'b0);

    // Two errors: (1,1) and (4,4)
    clean_frame(1'b0);
    cw_frame[1][1] = A * 7 + 8;
    cw_frame[4][4] = A * 28 - 2;
    build_expected();
    send_frame(1'b0, ROWS);
    drain_frame(-1, 0, 1'b0);

    // out_ready low for 3 cycles mid-drain
    clean_frame(1'b1);
    inject(3, 2, 9, 1'b1);
    build_expected();
    send_frame(1'b0, ROWS);
    drain_frame(2, 3, 1'b0);

    // Single error whose correction would give a negative message
    clean_frame(1'b0);
    cw_frame[5][5] = 3;
    build_expected();
    send_frame(1'b0, ROWS);
    drain_frame(-1, 0, 1'b0);

    // Reset after 3 rows of a frame carrying an error
    clean_frame(1'b0);
    inject(1, 4, 6, 1'b0);
    send_frame(1'b0, 3);
    rst = 1'b1;
    #1;
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midreset_in_ready_rise", 64'(in_ready), 64'(1));
    clean_frame(1'b0);
    build_expected();
    send_frame(1'b0, ROWS);
    drain_frame(-1, 0, 1'b0);

    // Randomized frames with 0, 1 or 2 errors
    for (int f = 0; f < 24; f++) begin
      clean_frame(1'b1);
      r1 = int'($urandom_range(0, ROWS - 1));
      c1 = int'($urandom_range(0, COLS - 1));
      if (f % 3 >= 1) inject(r1, c1, int'($urandom_range(0, CW_W - 1)), 1'($urandom_range(0, 1)));
      if (f % 3 == 2) begin
        do begin
          r2 = int'($urandom_range(0, ROWS - 1));
          c2 = int'($urandom_range(0, COLS - 1));
        end while (r2 == r1 && c2 == c1);
        inject(r2, c2, int'($urandom_range(0, CW_W - 1)), 1'($urandom_range(0, 1)));
      end
      build_expected();
      send_frame(1'b1, ROWS);
      drain_frame(-1, 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/an_product_decoder.md
# an_product_decoder

Streaming, parametrised successor to the fixed 6x6 AN-code product decoder.
- Accepts a ROWS x COLS frame of AN-coded codewords (codeword = A·m + e), one row per beat, and buffers the frame.
- Derives row and column error flags from per-cell Barrett residues and corrects a single arithmetic error at the flagged row/column intersection.
- Emits the decoded messages one row per beat, with frame status.
- Sits between the codeword receive path and message consumers; valid/ready on both sides.

## Interface
Parameters:
- A, 29: AN-code multiplier; must be odd, with order of 2 mod A ≥ 2·CW_W.
- CW_W, 14: codeword width.
- MSG_W, 10: message/quotient width.
- ROWS, 6: rows per frame.
- COLS, 6: codewords per row.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input row valid.
- in_ready  out  1  block can accept a row.
- in_data  in  COLS·CW_W  row of codewords; column c at [c·CW_W +: CW_W].
- out_valid  out  1  output row valid.
- out_ready  in  1  consumer accepts row.
- out_data  out  COLS·MSG_W  decoded messages; column c at [c·MSG_W +: MSG_W].
- out_last  out  1  final row of frame.
- out_corrected  out  1  frame had one error, corrected; held for whole drain.
- out_uncorr  out  1  frame had an uncorrectable error pattern; held for whole drain.

## Operation
Per-cell arithmetic at input:
- q = floor(cw/A), MSG_W bits.
- r = cw mod A, ⌈log2 A⌉ bits.
- err = (r ≠ 0).
- q and r for all cells are stored in a frame buffer.
- Er[row] = OR of err across the row; Ec |= err vector, accumulated per beat.

States:
- LOAD: in_ready=1. Each accepted beat stores the row at row_cnt and increments row_cnt. The beat with row_cnt = ROWS-1 moves to DECIDE and clears row_cnt.
- DECIDE (1 cycle), with nr = popcount(Er) and nc = popcount(Ec):
  - nr=0, nc=0: clean.
  - nr=1, nc=1: correct cell (i,j); m = q + DELTA[r], where DELTA[r] = (r − e_r)/A and e_r is the unique ±2^k (k < CW_W) with e_r ≡ r mod A. The result is written back to the buffer and out_corrected is set. If m < 0 or m ≥ 2^MSG_W, the write is suppressed and out_uncorr is set instead.
  - Any other combination: out_uncorr=1; data passes uncorrected (raw q).
- DRAIN: out_valid=1 and presents row drain_cnt. Each handshake increments drain_cnt. out_last=1 when drain_cnt = ROWS-1. The last handshake returns to LOAD and clears Er, Ec and both status flags.
- in_ready=0 in DECIDE and DRAIN (single frame buffer; no overlap).
- Reset at any time, including mid-frame or mid-drain: discard the frame, go to LOAD with counters 0.

Reset values:
- in_ready=0; it rises the first cycle after rst deasserts.
- out_valid=0, out_last=0, out_corrected=0, out_uncorr=0, out_data=0.

## Timing
- Accept-to-output latency: the last input beat is accepted at edge t; DECIDE occupies cycle t+1; out_valid=1 from cycle t+2.
- Drain takes ROWS cycles minimum; out_ready low stalls with out_data and flags stable.
- Frame period is at least 2·ROWS+1 cycles.
- out_valid must not drop without a handshake.
- in_valid may toggle freely; only handshaked beats count.

## Configuration
- AN_PRODUCT_CORRECT_EN defined: DECIDE behaves as above, including the single-cell correction.
- Undefined: detection only. Any flagged cell sets out_uncorr, out_corrected stays 0, DELTA logic is absent, and data is always raw q. Timing is unchanged (DECIDE cycle kept).

## Structure
Package an_product_pkg holds:
- A, width constants, and the state enum.
- A function building the DELTA[0..A-1] signed table at elaboration (DELTA[0]=0).

Sub-module an_barrett_lane is combinational, CW_W → q, r, err, and is instantiated COLS times on the input path.

## Test plan
- Clean frame, all cells cw = 29·(row·6+col): out_data messages 0..35 in order; corrected=0, uncorr=0; out_valid at t+2.
- Cell (2,3), message 100, with +2^5 error (cw=2932): out row 2 col 3 = 100; corrected=1; all other cells unchanged.
- Cell (0,0), message 5, with −2^0 error (cw=144, r=28): output 5, corrected=1.
- Errors in (1,1) and (4,4): uncorr=1, corrected=0, raw quotients output.
- out_ready held low 3 cycles mid-drain: row data and flags stable; exactly ROWS handshakes; then in_ready=1.
- rst asserted after 3 input rows: outputs 0 immediately; the next full frame decodes cleanly with no leftover flags.
